// File: rtl/dot_acc_ctrl.sv
// dot_acc_ctrl: sequential accumulation controller around a 2-lane 8-bit MAC.
// Ports: clk, rst_n (async low); in_valid/in_ready + in_a0/a1/b0/b1 beat
// input; mac_a*/mac_b*/mac_csum_in to the MAC, mac_csum_out from it;
// out_valid/out_ready + out_sum result. Optional macro DOT_ACC_OVF_EN adds
// an exact shadow sum and the out_ovf output.
module dot_acc_ctrl #(
    parameter int K_PAIRS = 8,
    parameter int ACC_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [7:0]       in_a0,
    input  logic signed [7:0]       in_a1,
    input  logic signed [7:0]       in_b0,
    input  logic signed [7:0]       in_b1,
    output logic signed [7:0]       mac_a0,
    output logic signed [7:0]       mac_a1,
    output logic signed [7:0]       mac_b0,
    output logic signed [7:0]       mac_b1,
    output logic signed [ACC_W-1:0] mac_csum_in,
    input  logic signed [ACC_W-1:0] mac_csum_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum
`ifdef DOT_ACC_OVF_EN
    ,
    output logic                    out_ovf
`endif
);

    localparam int CW = (K_PAIRS > 1) ? $clog2(K_PAIRS) : 1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                 state;
    logic [CW-1:0]          beat_cnt;
    logic signed [ACC_W-1:0] acc;
    logic                   last;

    assign mac_a0 = in_a0;
    assign mac_a1 = in_a1;
    assign mac_b0 = in_b0;
    assign mac_b1 = in_b1;

    // Beat 0 feeds zero, so no clear cycle is needed between results.
    assign mac_csum_in = (beat_cnt == '0) ? '0 : acc;

    assign in_ready = (state == ACCUM);
    assign last     = (beat_cnt == CW'(K_PAIRS - 1));

`ifdef DOT_ACC_OVF_EN
    localparam int SW = 18 + $clog2(K_PAIRS);

    logic signed [SW-1:0] shadow;
    logic signed [SW-1:0] base;
    logic signed [SW-1:0] exact;
    logic signed [15:0]   a0x, a1x, b0x, b1x;
    logic signed [15:0]   p0, p1;
    logic signed [16:0]   psum;
    logic                 ovf;

    assign a0x  = {{8{in_a0[7]}}, in_a0};
    assign a1x  = {{8{in_a1[7]}}, in_a1};
    assign b0x  = {{8{in_b0[7]}}, in_b0};
    assign b1x  = {{8{in_b1[7]}}, in_b1};
    assign p0   = a0x * b0x;
    assign p1   = a1x * b1x;
    assign psum = {p0[15], p0} + {p1[15], p1};
    assign base = (beat_cnt == '0) ? '0 : shadow;
    assign exact = base + {{(SW-17){psum[16]}}, psum};

    // Out of 16-bit range when the bits above the result sign disagree.
    assign ovf = (exact[SW-1:ACC_W-1] != '0) &&
                 (exact[SW-1:ACC_W-1] != '1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            beat_cnt  <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
`ifdef DOT_ACC_OVF_EN
            shadow    <= '0;
            out_ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (last) begin
                            out_sum   <= mac_csum_out;
                            beat_cnt  <= '0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
`ifdef DOT_ACC_OVF_EN
                            out_ovf   <= ovf;
`endif
                        end else begin
                            acc      <= mac_csum_out;
                            beat_cnt <= beat_cnt + CW'(1);
`ifdef DOT_ACC_OVF_EN
                            shadow   <= exact;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_acc_ctrl.sv
// tb_dot_acc_ctrl: randomized self-checking bench for dot_acc_ctrl (K_PAIRS=4)
// with a behavioural MAC and an integer dot-product reference model.
module tb_dot_acc_ctrl;

    localparam int K = 4;

    typedef struct {
        logic signed [7:0] a0, b0, a1, b1;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_a0, in_a1, in_b0, in_b1;
    logic signed [7:0]  mac_a0, mac_a1, mac_b0, mac_b1;
    logic signed [15:0] mac_csum_in;
    logic signed [15:0] mac_csum_out;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_sum;
`ifdef DOT_ACC_OVF_EN
    logic               out_ovf;
`endif

    dot_acc_ctrl #(.K_PAIRS(K), .ACC_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a0        (in_a0),
        .in_a1        (in_a1),
        .in_b0        (in_b0),
        .in_b1        (in_b1),
        .mac_a0       (mac_a0),
        .mac_a1       (mac_a1),
        .mac_b0       (mac_b0),
        .mac_b1       (mac_b1),
        .mac_csum_in  (mac_csum_in),
        .mac_csum_out (mac_csum_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum)
`ifdef DOT_ACC_OVF_EN
        ,
        .out_ovf      (out_ovf)
`endif
    );

    // Behavioural MAC: wraps to 16 bits like the real datapath.
    always_comb begin
        int t;
        t = int'(mac_csum_in) + int'(mac_a0) * int'(mac_b0)
          + int'(mac_a1) * int'(mac_b1);
        mac_csum_out = t[15:0];
    end

    int checks = 0;
    int errors = 0;
    beat_t cur[$];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int a0, input int b0,
                        input int a1, input int b1);
        beat_t b;
        cur.delete();
        b.a0 = 8'(a0); b.b0 = 8'(b0);
        b.a1 = 8'(a1); b.b1 = 8'(b1);
        for (int i = 0; i < K; i++) cur.push_back(b);
    endtask

    task automatic fill_rand();
        beat_t b;
        cur.delete();
        for (int i = 0; i < K; i++) begin
            b.a0 = 8'($urandom); b.b0 = 8'($urandom);
            b.a1 = 8'($urandom); b.b1 = 8'($urandom);
            cur.push_back(b);
        end
    endtask

    task automatic rand_ops();
        in_a0 = 8'($urandom); in_a1 = 8'($urandom);
        in_b0 = 8'($urandom); in_b1 = 8'($urandom);
    endtask

    // bub: 0 none, 1 one bubble between beats, 2 random 0..2 bubbles.
    task automatic run_dot(input string tag, input int bub,
                           input int stall);
        int total;
        int nb;
        logic signed [15:0] e;
        total = 0;
        for (int i = 0; i < K; i++) begin
            nb = 0;
            if (bub == 1 && i > 0) nb = 1;
            if (bub == 2) nb = $urandom_range(0, 2);
            for (int j = 0; j < nb; j++) begin
                in_valid  = 1'b0;
                out_ready = 1'($urandom);
                rand_ops();
                @(posedge clk); #1;
            end
            in_valid  = 1'b1;
            out_ready = 1'($urandom);
            in_a0 = cur[i].a0; in_b0 = cur[i].b0;
            in_a1 = cur[i].a1; in_b1 = cur[i].b1;
            #1;
            e = total[15:0];
            chk({tag, "_in_ready"}, in_ready, 1);
            chk({tag, "_csum_in"}, mac_csum_in, e);
            chk({tag, "_mac_a1"}, mac_a1, cur[i].a1);
            chk({tag, "_mac_b0"}, mac_b0, cur[i].b0);
            total += int'(cur[i].a0) * int'(cur[i].b0)
                   + int'(cur[i].a1) * int'(cur[i].b1);
            if (i < K - 1) begin
                @(posedge clk); #1;
                chk({tag, "_mid_valid"}, out_valid, 0);
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        e = total[15:0];
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_hold_ready"}, in_ready, 0);
        chk({tag, "_out_sum"}, out_sum, e);
`ifdef DOT_ACC_OVF_EN
        chk({tag, "_ovf"}, out_ovf,
            (total > 32767 || total < -32768) ? 1 : 0);
`endif
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom);
            rand_ops();
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_sum"}, out_sum, e);
            chk({tag, "_stall_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, out_valid, 0);
        chk({tag, "_back_ready"}, in_ready, 1);
        chk({tag, "_kept_sum"}, out_sum, e);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a0 = '0; in_a1 = '0; in_b0 = '0; in_b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_csum_in", mac_csum_in, 0);
`ifdef DOT_ACC_OVF_EN
        chk("rst_ovf", out_ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fill(1, 2, 3, 4);
        run_dot("basic", 0, 0);
        run_dot("stall5", 0, 5);
        run_dot("after_stall", 0, 0);
        fill(-128, -128, -128, 127);
        run_dot("signed", 0, 1);
        fill(1, 2, 3, 4);
        run_dot("bubbles", 1, 0);
        fill(127, 127, 127, 127);
        run_dot("wrap", 0, 0);
        chk("wrap_value", out_sum, -2040);

        // Reset mid dot product, two beats in.
        fill(1, 2, 3, 4);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a0 = cur[i].a0; in_b0 = cur[i].b0;
            in_a1 = cur[i].a1; in_b1 = cur[i].b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_sum", out_sum, 0);
        chk("midrst_csum_in", mac_csum_in, 0);
`ifdef DOT_ACC_OVF_EN
        chk("midrst_ovf", out_ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_dot("post_rst", 0, 0);
        chk("post_rst_value", out_sum, 56);

        for (int n = 0; n < 25; n++) begin
            fill_rand();
            run_dot("rand", 2, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_acc_ctrl.md
# dot_acc_ctrl

Sequential accumulation controller for the two-lane 8-bit MAC datapath. It accepts a stream of operand-pair beats over a valid/ready handshake and presents each beat's operands to the combinational MAC. It feeds the running partial sum back into the MAC's partial-sum input and registers the MAC's partial-sum output. After K_PAIRS beats it emits one signed 16-bit dot-product result on a valid/ready output, so a full dot product of length 2*K_PAIRS takes K_PAIRS accepted beats.

## Interface
- K_PAIRS, 8: beats per dot product; legal range 1..256.
- ACC_W, 16: accumulator and result width; fixed to the MAC sum width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat present.
- in_ready  out  1  block accepts a beat.
- in_a0, in_a1, in_b0, in_b1  in  8 signed  operand pair for this beat.
- mac_a0, mac_a1, mac_b0, mac_b1  out  8 signed  to the MAC operand inputs.
- mac_csum_in  out  16 signed  to the MAC partial-sum input.
- mac_csum_out  in  16 signed  from the MAC partial-sum output.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_sum  out  16 signed  dot-product result.
- out_ovf  out  1  true sum exceeded 16-bit signed range. Present only with DOT_ACC_OVF_EN.

## Operation
- States:
  - ACCUM (reset state): in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- Reset values: state=ACCUM, beat_cnt=0, acc=0, out_valid=0, out_sum=0, out_ovf=0.
- mac_a*/mac_b* are combinational pass-throughs of in_a*/in_b*.
- mac_csum_in = 0 when beat_cnt==0, else acc. Each dot product therefore starts from zero, with no clear cycle.
- Accept = in_valid && in_ready.
  - On accept with beat_cnt < K_PAIRS-1: acc <= mac_csum_out, beat_cnt++.
  - On accept with beat_cnt == K_PAIRS-1: out_sum <= mac_csum_out, beat_cnt <= 0, state <= HOLD.
- HOLD: out_sum is held stable and no beat is accepted. When out_ready=1, out_valid drops next cycle and state returns to ACCUM.
- Arithmetic is two's complement and wraps modulo 2^16. Wrap-around is the MAC's native behaviour, so this block adds no saturation.
- K_PAIRS=1: every accepted beat goes straight to HOLD.
- Gaps in in_valid (bubbles) do not affect the result; acc and beat_cnt hold.
- Reset asserted mid-dot-product: the partial sum and beat count are discarded. After release the next beat is beat 0.

## Timing
- Result latency: out_valid rises on the clock edge that accepts the last beat, i.e. it is visible the cycle after that beat is presented.
- Minimum period per dot product: K_PAIRS+1 cycles with in_valid and out_ready held high (one HOLD cycle).
- in_ready depends only on state, never combinationally on out_ready or in_valid.
- The MAC path (in_* -> mac_* -> mac_csum_out -> acc) is a single-cycle combinational path ending at the acc/out_sum registers.
- out_valid, once high, stays high and out_sum stays constant until a cycle with out_ready=1.

## Configuration
- DOT_ACC_OVF_EN defined:
  - Adds a shadow signed accumulator of width 18+ceil(log2(K_PAIRS)). It sums a0*b0+a1*b1 exactly alongside acc.
  - out_ovf is loaded with out_sum. It is 1 if the exact final sum lies outside [-32768, 32767].
  - The shadow accumulator resets to 0 and restarts at beat 0 together with acc.
- DOT_ACC_OVF_EN undefined: no shadow logic and no out_ovf port. Behaviour is otherwise identical.

## Test plan
- K_PAIRS=4, four beats (a0,b0,a1,b1)=(1,2,3,4), back-to-back -> out_valid high the cycle after the 4th accept, out_sum=56.
- K_PAIRS=4, four beats (-128,-128,-128,127) -> out_sum=512; checks signed multiply through the MAC.
- Result stalled with out_ready=0 for 5 cycles:
  - out_valid=1, out_sum=56 stable, in_ready=0, no beat consumed.
  - After release, the next four (1,2,3,4) beats give 56 again (acc restarted from 0).
- in_valid toggled 1,0,1,0... across the four (1,2,3,4) beats -> out_sum=56, beat_cnt unaffected by bubbles.
- Four beats (127,127,127,127) -> out_sum=-2040 (129032 wrapped). With DOT_ACC_OVF_EN, out_ovf=1; for the 56 case, out_ovf=0.
- rst_n pulsed low after 2 of 4 beats -> all outputs return to reset values. Four fresh (1,2,3,4) beats then give out_sum=56.
